// File: rtl/mips_multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_control_pkg
// Brief   : Shared encodings for the multi-cycle MIPS control FSM.
// Revision: 1.0 - initial release
// ============================================================================
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    // Instruction class held from DECODE through the execute states
    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_LW   = 3'd2,
        C_SW   = 3'd3,
        C_IMM  = 3'd4,
        C_BEQ  = 3'd5,
        C_BNE  = 3'd6,
        C_J    = 3'd7
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    function automatic iclass_e op_class(input logic [5:0] op);
        case (op)
            OP_RTYPE:                  return C_R;
            OP_LW:                     return C_LW;
            OP_SW:                     return C_SW;
            OP_ADDI, OP_ORI, OP_SLTI:  return C_IMM;
            OP_BEQ:                    return C_BEQ;
            OP_BNE:                    return C_BNE;
            OP_J:                      return C_J;
            default:                   return C_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_control_if
// Brief   : Instruction-field, memory-handshake and datapath-control bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface mips_multicycle_control_if;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;

    logic       ir_write_o;
    logic       pc_en_o;
    logic [1:0] pc_source_o;
    logic       iord_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       reg_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_ctrl_o;
    logic       illegal_op_o;
    logic       bus_error_o;
    logic [3:0] state_o;

    modport slave (
        input  opcode_i, funct_i, zero_i, mem_ready_i,
        output ir_write_o, pc_en_o, pc_source_o, iord_o, mem_read_o, mem_write_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_ctrl_o, illegal_op_o, bus_error_o, state_o
    );

    modport master (
        output opcode_i, funct_i, zero_i, mem_ready_i,
        input  ir_write_o, pc_en_o, pc_source_o, iord_o, mem_read_o, mem_write_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_ctrl_o, illegal_op_o, bus_error_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/mips_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module  : mips_alu_ctrl_decode
// Brief   : Combinational opcode/funct -> ALU control and legality decode.
// Revision: 1.0 - initial release
// ============================================================================
module mips_alu_ctrl_decode
    import mips_multicycle_control_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output alu_ctrl_e  alu_ctrl_o,
    output logic       legal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: legal_o    = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI, OP_J: alu_ctrl_o = ALU_ADD;
            OP_ORI:                      alu_ctrl_o = ALU_OR;
            OP_SLTI:                     alu_ctrl_o = ALU_SLT;
            OP_BEQ, OP_BNE:              alu_ctrl_o = ALU_SUB;
            default:                     legal_o    = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_control
// Brief   : Multi-cycle MIPS main control FSM with memory-wait watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    mips_multicycle_control_if.slave       bus
);

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    state_e    state_q, state_d;
    iclass_e   class_q;
    alu_ctrl_e alu_q;
    logic [7:0] wait_cnt_q;

    alu_ctrl_e dec_alu;
    logic      dec_legal;
    logic      wait_state;
    logic      timeout;

    mips_alu_ctrl_decode u_alu_dec (
        .opcode_i   (bus.opcode_i),
        .funct_i    (bus.funct_i),
        .alu_ctrl_o (dec_alu),
        .legal_o    (dec_legal)
    );

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready in the limit cycle completes the access instead of aborting it
    assign timeout    = wait_state && !bus.mem_ready_i && (wait_cnt_q >= LIMIT_M1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready_i)  state_d = S_DECODE;
                else if (timeout)     state_d = S_IDLE;
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (op_class(bus.opcode_i))
                        C_R:          state_d = S_R_EXEC;
                        C_LW, C_SW:   state_d = S_MEM_ADDR;
                        C_IMM:        state_d = S_I_EXEC;
                        C_BEQ, C_BNE: state_d = S_BRANCH;
                        C_J:          state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: state_d = (class_q == C_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.mem_ready_i)  state_d = S_MEM_WB;
                else if (timeout)     state_d = S_IDLE;
            end
            S_MEM_WR: begin
                if (bus.mem_ready_i)  state_d = S_FETCH;
                else if (timeout)     state_d = S_IDLE;
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            class_q    <= C_NONE;
            alu_q      <= ALU_ADD;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                class_q <= op_class(bus.opcode_i);
                alu_q   <= dec_alu;
            end
            // Any state change restarts the count; only wait states ever self-loop
            if (state_d != state_q)
                wait_cnt_q <= 8'd0;
            else if (wait_cnt_q != 8'hFF)
                wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    logic       ir_write, pc_en, iord, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_ctrl;

    always_comb begin
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = bus.mem_ready_i;
                pc_en     = bus.mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_ctrl   = ALU_ADD;
                illegal_op = !dec_legal;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = (state_q == S_I_EXEC) ? alu_q : ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = alu_q;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_source = 2'b01;
                pc_en     = (class_q == C_BNE) ? !bus.zero_i : bus.zero_i;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ir_write_o   = ir_write;
    assign bus.pc_en_o      = pc_en;
    assign bus.pc_source_o  = pc_source;
    assign bus.iord_o       = iord;
    assign bus.mem_read_o   = mem_read;
    assign bus.mem_write_o  = mem_write;
    assign bus.reg_write_o  = reg_write;
    assign bus.reg_dst_o    = reg_dst;
    assign bus.mem_to_reg_o = mem_to_reg;
    assign bus.alu_src_a_o  = alu_src_a;
    assign bus.alu_src_b_o  = alu_src_b;
    assign bus.alu_ctrl_o   = alu_ctrl;
    assign bus.illegal_op_o = illegal_op;
    assign bus.bus_error_o  = timeout;
    assign bus.state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_multicycle_control
// Brief   : Self-checking bench; per-instruction cycle sequences from a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;
    import mips_multicycle_control_pkg::*;

    localparam int WL = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ir_write, pc_en;
        logic [1:0] pc_source;
        logic       iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       illegal_op, bus_error;
    } ctl_t;

    typedef struct {
        logic [5:0] op, fn;
        logic       rdy, z;
        logic [3:0] st;
        ctl_t       c;
    } step_t;

    step_t      q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] cur_op, cur_fn;

    function automatic ctl_t observed();
        ctl_t o;
        o.ir_write   = bus.ir_write_o;
        o.pc_en      = bus.pc_en_o;
        o.pc_source  = bus.pc_source_o;
        o.iord       = bus.iord_o;
        o.mem_read   = bus.mem_read_o;
        o.mem_write  = bus.mem_write_o;
        o.reg_write  = bus.reg_write_o;
        o.reg_dst    = bus.reg_dst_o;
        o.mem_to_reg = bus.mem_to_reg_o;
        o.alu_src_a  = bus.alu_src_a_o;
        o.alu_src_b  = bus.alu_src_b_o;
        o.alu_ctrl   = bus.alu_ctrl_o;
        o.illegal_op = bus.illegal_op_o;
        o.bus_error  = bus.bus_error_o;
        return o;
    endfunction

    // {legal, alu_ctrl} straight from the instruction table
    function automatic logic [3:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: case (fn)
                6'b100000: return 4'b1_010;
                6'b100010: return 4'b1_110;
                6'b100100: return 4'b1_000;
                6'b100101: return 4'b1_001;
                6'b101010: return 4'b1_111;
                default:   return 4'b0_010;
            endcase
            6'b100011, 6'b101011, 6'b001000: return 4'b1_010;
            6'b001101:                       return 4'b1_001;
            6'b001010:                       return 4'b1_111;
            6'b000100, 6'b000101:            return 4'b1_110;
            6'b000010:                       return 4'b1_010;
            default:                         return 4'b0_010;
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input ctl_t c, input logic rdy, input logic z);
        step_t s;
        s.op = cur_op; s.fn = cur_fn; s.rdy = rdy; s.z = z; s.st = st; s.c = c;
        q.push_back(s);
    endtask

    // Memory wait state: 'waits' idle cycles, then ready, or abort at the limit
    task automatic push_wait(input logic [3:0] st, input ctl_t c, input int waits,
                             input bit fetch, output bit aborted);
        ctl_t cc;
        for (int i = 0; i < waits && i < WL; i++) begin
            cc = c;
            if (i == WL - 1) cc.bus_error = 1'b1;
            push(st, cc, 1'b0, 1'($urandom_range(0, 1)));
        end
        if (waits >= WL) begin
            push(S_IDLE, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            aborted = 1'b1;
        end else begin
            cc = c;
            if (fetch) begin cc.ir_write = 1'b1; cc.pc_en = 1'b1; end
            push(st, cc, 1'b1, 1'($urandom_range(0, 1)));
            aborted = 1'b0;
        end
    endtask

    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int fw, input int mw);
        ctl_t c;
        bit   ab;
        logic [3:0] la;
        cur_op = op; cur_fn = fn;
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
        push_wait(S_FETCH, c, fw, 1'b1, ab);
        if (!ab) begin
            la = ref_alu(op, fn);
            c = '0; c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010; c.illegal_op = !la[3];
            push(S_DECODE, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            // Fields are junk after DECODE; the FSM must rely on what it latched
            cur_op = 6'($urandom); cur_fn = 6'($urandom);
            if (la[3]) begin
                c = '0;
                case (op)
                    6'b000000: begin
                        c.alu_src_a = 1'b1; c.alu_ctrl = la[2:0];
                        push(S_R_EXEC, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
                        push(S_R_WB, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end
                    6'b100011, 6'b101011: begin
                        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
                        push(S_MEM_ADDR, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        c = '0; c.iord = 1'b1;
                        if (op == 6'b100011) begin
                            c.mem_read = 1'b1;
                            push_wait(S_MEM_RD, c, mw, 1'b0, ab);
                            if (!ab) begin
                                c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                                push(S_MEM_WB, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                            end
                        end else begin
                            c.mem_write = 1'b1;
                            push_wait(S_MEM_WR, c, mw, 1'b0, ab);
                        end
                    end
                    6'b001000, 6'b001101, 6'b001010: begin
                        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = la[2:0];
                        push(S_I_EXEC, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        c = '0; c.reg_write = 1'b1;
                        push(S_I_WB, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end
                    6'b000100, 6'b000101: begin
                        c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110; c.pc_source = 2'b01;
                        c.pc_en = (op == 6'b000100) ? z : !z;
                        push(S_BRANCH, c, 1'($urandom_range(0, 1)), z);
                    end
                    default: begin
                        c.pc_source = 2'b10; c.pc_en = 1'b1;
                        push(S_JUMP, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end
                endcase
            end
        end
    endtask

    task automatic apply_step(output step_t s);
        s = q.pop_front();
        @(negedge clk);
        bus.opcode_i    = s.op;
        bus.funct_i     = s.fn;
        bus.mem_ready_i = s.rdy;
        bus.zero_i      = s.z;
        #1;
    endtask

    task automatic test_reset();
        step_t s;
        bus.opcode_i = 6'b000000; bus.funct_i = 6'b100000;
        bus.mem_ready_i = 1'b1; bus.zero_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.state_o !== S_IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d want %0d", bus.state_o, S_IDLE);
        end
        n_cmp++;
        if (observed() !== ctl_t'(0)) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", observed());
        end
        @(negedge clk);
        reset = 1'b0;
        push_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL reset_release_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL reset_release_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    task automatic test_add();
        step_t s;
        push_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        push_instr(6'b000000, 6'b101010, 1'b0, 2, 0);
        push_instr(6'b001101, 6'b000000, 1'b0, 0, 0);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL add_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL add_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    task automatic test_lw_stall();
        step_t s;
        push_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
        push_instr(6'b101011, 6'b000000, 1'b0, 1, 2);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL lw_stall_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL lw_stall_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    task automatic test_branch();
        step_t s;
        push_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        push_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
        push_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        push_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
        push_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL branch_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL branch_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    task automatic test_illegal();
        step_t s;
        push_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        push_instr(6'b000000, 6'b000001, 1'b0, 0, 0);
        push_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL illegal_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL illegal_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    task automatic test_watchdog();
        step_t s;
        push_instr(6'b000000, 6'b100000, 1'b0, WL, 0);      // abort in FETCH
        push_instr(6'b000000, 6'b100010, 1'b0, WL - 1, 0);  // ready in limit cycle wins
        push_instr(6'b101011, 6'b000000, 1'b0, 0, WL);      // abort in MEM_WR
        push_instr(6'b100011, 6'b000000, 1'b0, 0, WL + 5);  // abort in MEM_RD
        push_instr(6'b100011, 6'b000000, 1'b0, 0, WL - 1);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL watchdog_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL watchdog_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        step_t s;
        ctl_t  c;
        bit    ab;
        cur_op = 6'b100011; cur_fn = 6'b000000;
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
        push_wait(S_FETCH, c, 0, 1'b1, ab);
        c = '0; c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010;
        push(S_DECODE, c, 1'b0, 1'b0);
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
        push(S_MEM_ADDR, c, 1'b0, 1'b0);
        c = '0; c.mem_read = 1'b1; c.iord = 1'b1;
        push(S_MEM_RD, c, 1'b0, 1'b0);
        push(S_MEM_RD, c, 1'b0, 1'b0);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL midrst_pre_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL midrst_pre_ctl: got %h want %h", observed(), s.c);
            end
        end
        #2;
        bus.mem_ready_i = 1'b1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.state_o !== S_IDLE) begin
            n_bad++; $display("FAIL midrst_state: got %0d want %0d", bus.state_o, S_IDLE);
        end
        n_cmp++;
        if (observed() !== ctl_t'(0)) begin
            n_bad++; $display("FAIL midrst_outputs: got %h want 0", observed());
        end
        @(negedge clk);
        reset = 1'b0;
        push_instr(6'b101011, 6'b000000, 1'b0, 0, 1);
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL midrst_post_state: got %0d want %0d", bus.state_o, s.st);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL midrst_post_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    task automatic test_random();
        step_t      s;
        logic [5:0] ops [10];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        int         fw, mw;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101,
                6'b001010, 6'b000100, 6'b000101, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            fw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(WL - 1, WL + 1))
                                              : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(WL - 1, WL + 1))
                                              : int'($urandom_range(0, 3));
            push_instr(op, fn, 1'($urandom_range(0, 1)), fw, mw);
        end
        while (q.size() != 0) begin
            apply_step(s);
            n_cmp++;
            if (bus.state_o !== s.st) begin
                n_bad++; $display("FAIL random_state: got %0d want %0d (op %b)", bus.state_o, s.st, s.op);
            end
            n_cmp++;
            if (observed() !== s.c) begin
                n_bad++; $display("FAIL random_ctl: got %h want %h", observed(), s.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_illegal();
        test_watchdog();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
